// File: rtl/mult_pipe_ff.sv
// Pipelined A*B multiplier with 0-2 input and 0-2 output register stages.
// Every stage has async reset, sync clear and clock enable; an optional accumulator sits in the first output stage.
module mult_pipe_ff #(
    parameter int A_WIDTH    = 9,
    parameter int B_WIDTH    = 9,
    parameter int Z_WIDTH    = 18,
    parameter int IN_STAGES  = 1,
    parameter int OUT_STAGES = 1,
    parameter int SIGNED     = 0,
    parameter int ACCUM      = 0
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               SRST,
    input  logic               CE,
    input  logic               IN_VALID,
    input  logic               LOAD,
    input  logic [A_WIDTH-1:0] A,
    input  logic [B_WIDTH-1:0] B,
    output logic               OUT_VALID,
    output logic [Z_WIDTH-1:0] Z
);

    if (Z_WIDTH < A_WIDTH + B_WIDTH) begin : g_bad_z_width
        $error("mult_pipe_ff: Z_WIDTH must be >= A_WIDTH + B_WIDTH");
    end
    if (ACCUM != 0 && OUT_STAGES < 1) begin : g_bad_accum
        $error("mult_pipe_ff: ACCUM=1 requires OUT_STAGES >= 1");
    end
    if (IN_STAGES < 0 || IN_STAGES > 2 || OUT_STAGES < 0 || OUT_STAGES > 2) begin : g_bad_stages
        $error("mult_pipe_ff: IN_STAGES and OUT_STAGES must be in 0..2");
    end

    logic [A_WIDTH-1:0] a_d;
    logic [B_WIDTH-1:0] b_d;
    logic               valid_d;
    logic               load_d;

    if (IN_STAGES == 0) begin : g_in_comb
        assign a_d     = A;
        assign b_d     = B;
        assign valid_d = IN_VALID;
        assign load_d  = LOAD;
    end else begin : g_in_reg
        logic [A_WIDTH-1:0]   a_r [IN_STAGES];
        logic [B_WIDTH-1:0]   b_r [IN_STAGES];
        logic [IN_STAGES-1:0] valid_r;
        logic [IN_STAGES-1:0] load_r;

        // NOTE: state is updated with <= only, so every stage samples its predecessor's pre-edge value.
        always_ff @(posedge CLK or posedge RST) begin
            // NOTE: these arrays are a handful of pipeline flops, not RAM, so clearing them on reset is intended.
            if (RST) begin
                for (int i = 0; i < IN_STAGES; i++) begin
                    a_r[i] <= '0;
                    b_r[i] <= '0;
                end
                valid_r <= '0;
                load_r  <= '0;
            end else if (SRST) begin
                for (int i = 0; i < IN_STAGES; i++) begin
                    a_r[i] <= '0;
                    b_r[i] <= '0;
                end
                valid_r <= '0;
                load_r  <= '0;
            end else if (CE) begin
                a_r[0]     <= A;
                b_r[0]     <= B;
                valid_r[0] <= IN_VALID;
                load_r[0]  <= LOAD;
                for (int i = 1; i < IN_STAGES; i++) begin
                    a_r[i]     <= a_r[i-1];
                    b_r[i]     <= b_r[i-1];
                    valid_r[i] <= valid_r[i-1];
                    load_r[i]  <= load_r[i-1];
                end
            end
        end

        assign a_d     = a_r[IN_STAGES-1];
        assign b_d     = b_r[IN_STAGES-1];
        assign valid_d = valid_r[IN_STAGES-1];
        assign load_d  = load_r[IN_STAGES-1];
    end

    // Extending both operands to Z_WIDTH first makes the truncated product equal the extended full product.
    logic [Z_WIDTH-1:0] a_x;
    logic [Z_WIDTH-1:0] b_x;
    logic [Z_WIDTH-1:0] prod;

    assign a_x  = {{(Z_WIDTH-A_WIDTH){SIGNED != 0 && a_d[A_WIDTH-1]}}, a_d};
    assign b_x  = {{(Z_WIDTH-B_WIDTH){SIGNED != 0 && b_d[B_WIDTH-1]}}, b_d};
    assign prod = a_x * b_x;

    if (OUT_STAGES == 0) begin : g_out_comb
        assign Z         = prod;
        assign OUT_VALID = valid_d;
    end else begin : g_out_reg
        logic [Z_WIDTH-1:0]    z_r [OUT_STAGES];
        logic [OUT_STAGES-1:0] valid_r;
        logic [Z_WIDTH-1:0]    first_next;

        // NOTE: first_next gets its default before any branch, so no latch can be inferred.
        always_comb begin
            first_next = prod;
            if (ACCUM != 0) begin
                first_next = z_r[0];
                if (valid_d) begin
                    first_next = load_d ? prod : z_r[0] + prod;
                end
            end
        end

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                for (int i = 0; i < OUT_STAGES; i++) begin
                    z_r[i] <= '0;
                end
                valid_r <= '0;
            end else if (SRST) begin
                for (int i = 0; i < OUT_STAGES; i++) begin
                    z_r[i] <= '0;
                end
                valid_r <= '0;
            end else if (CE) begin
                z_r[0]     <= first_next;
                valid_r[0] <= valid_d;
                for (int i = 1; i < OUT_STAGES; i++) begin
                    z_r[i]     <= z_r[i-1];
                    valid_r[i] <= valid_r[i-1];
                end
            end
        end

        assign Z         = z_r[OUT_STAGES-1];
        assign OUT_VALID = valid_r[OUT_STAGES-1];
    end

endmodule

// File: tb/tb_mult_pipe_ff.sv
// Bench for mult_pipe_ff: every IN_STAGES x OUT_STAGES x SIGNED variant plus one accumulator instance,
// all on shared stimulus, checked against a delay-line model of CE-qualified samples.
module tb_mult_pipe_ff;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       SRST, CE, IN_VALID, LOAD;
    logic [8:0] A, B;

    always #5 CLK = ~CLK;

    localparam int NCFG = 18;
    logic [17:0] sw_z  [NCFG];
    logic        sw_ov [NCFG];
    logic [19:0] acc_z;
    logic        acc_ov;

    for (genvar gi = 0; gi < 3; gi++) begin : g_in
        for (genvar go = 0; go < 3; go++) begin : g_out
            for (genvar gs = 0; gs < 2; gs++) begin : g_sg
                localparam int IDX = gi * 6 + go * 2 + gs;
                mult_pipe_ff #(
                    .A_WIDTH(9), .B_WIDTH(9), .Z_WIDTH(18),
                    .IN_STAGES(gi), .OUT_STAGES(go), .SIGNED(gs), .ACCUM(0)
                ) u_dut (
                    .CLK(CLK), .RST(RST), .SRST(SRST), .CE(CE),
                    .IN_VALID(IN_VALID), .LOAD(LOAD), .A(A), .B(B),
                    .OUT_VALID(sw_ov[IDX]), .Z(sw_z[IDX])
                );
            end
        end
    end

    mult_pipe_ff #(
        .A_WIDTH(9), .B_WIDTH(9), .Z_WIDTH(20),
        .IN_STAGES(1), .OUT_STAGES(1), .SIGNED(0), .ACCUM(1)
    ) u_acc (
        .CLK(CLK), .RST(RST), .SRST(SRST), .CE(CE),
        .IN_VALID(IN_VALID), .LOAD(LOAD), .A(A), .B(B),
        .OUT_VALID(acc_ov), .Z(acc_z)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Model: the last four samples captured on CE edges, newest first; clears wipe them.
    logic       hv [4];
    logic [8:0] ha [4];
    logic [8:0] hb [4];
    bit         last_ce;

    function automatic logic [17:0] model_prod(input logic [8:0] a, input logic [8:0] b, input bit sg);
        int sa, sb;
        sa = sg ? int'($signed(a)) : int'(a);
        sb = sg ? int'($signed(b)) : int'(b);
        return 18'(sa * sb);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            hv[i] = 1'b0;
            ha[i] = '0;
            hb[i] = '0;
        end
    endtask

    task automatic model_edge();
        last_ce = 1'b0;
        if (RST || SRST) begin
            model_clear();
        end else if (CE) begin
            for (int i = 3; i > 0; i--) begin
                hv[i] = hv[i-1];
                ha[i] = ha[i-1];
                hb[i] = hb[i-1];
            end
            hv[0]   = IN_VALID;
            ha[0]   = A;
            hb[0]   = B;
            last_ce = 1'b1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_all(input string tag);
        for (int c = 0; c < NCFG; c++) begin
            int         lat;
            logic       ev;
            logic [8:0] ea, eb;
            lat = c / 6 + (c / 2) % 3;
            if (lat == 0) begin
                ev = IN_VALID; ea = A; eb = B;
            end else begin
                ev = hv[lat-1]; ea = ha[lat-1]; eb = hb[lat-1];
            end
            check($sformatf("%s cfg%0d valid", tag, c), 32'(sw_ov[c]), 32'(ev));
            check($sformatf("%s cfg%0d z", tag, c), 32'(sw_z[c]), 32'(model_prod(ea, eb, c % 2 == 1)));
        end
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
    endtask

    task automatic flush();
        IN_VALID = 1'b0; CE = 1'b1; SRST = 1'b0; LOAD = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
    endtask

    typedef struct {
        logic [8:0]  a;
        logic [8:0]  b;
        bit          sg;
        logic [17:0] z;
    } vec_t;

    vec_t        vecs [8];
    logic [17:0] got_q [$];

    initial begin
        vecs[0] = '{a: 9'd200, b: 9'd3,   sg: 1'b0, z: 18'd600};
        vecs[1] = '{a: 9'h1FF, b: 9'd5,   sg: 1'b1, z: 18'h3FFFB};
        vecs[2] = '{a: 9'h100, b: 9'h100, sg: 1'b1, z: 18'd65536};
        vecs[3] = '{a: 9'h1FF, b: 9'h1FF, sg: 1'b0, z: 18'd261121};
        vecs[4] = '{a: 9'd0,   b: 9'd123, sg: 1'b0, z: 18'd0};
        vecs[5] = '{a: 9'h1FF, b: 9'h1FF, sg: 1'b1, z: 18'd1};
        vecs[6] = '{a: 9'd255, b: 9'd255, sg: 1'b1, z: 18'd65025};
        vecs[7] = '{a: 9'h100, b: 9'd1,   sg: 1'b1, z: 18'h3FF00};

        SRST = 1'b0; CE = 1'b0; IN_VALID = 1'b0; LOAD = 1'b0; A = '0; B = '0;
        model_clear();
        last_ce = 1'b0;
        #1 RST = 1'b1;
        #1;
        check_all("reset");
        check("reset acc valid", 32'(acc_ov), 32'd0);
        check("reset acc z", 32'(acc_z), 32'd0);
        cycle();
        cycle();
        RST = 1'b0;
        CE  = 1'b1;

        // Directed products, two CE edges from input to output on the default configuration.
        for (int v = 0; v < 8; v++) begin
            A = vecs[v].a; B = vecs[v].b; IN_VALID = 1'b1;
            cycle();
            IN_VALID = 1'b0; A = 9'($urandom); B = 9'($urandom);
            cycle();
            check($sformatf("vec%0d valid", v), 32'(sw_ov[8 + int'(vecs[v].sg)]), 32'd1);
            check($sformatf("vec%0d z", v), 32'(sw_z[8 + int'(vecs[v].sg)]), 32'(vecs[v].z));
            check_all("vec");
        end

        // Back-to-back samples with a one-cycle stall in the middle.
        flush();
        got_q.delete();
        for (int i = 0; i < 8; i++) begin
            case (i)
                0:       begin IN_VALID = 1'b1; A = 9'd2; B = 9'd3; CE = 1'b1; end
                1:       begin IN_VALID = 1'b1; A = 9'd4; B = 9'd5; CE = 1'b1; end
                2:       begin IN_VALID = 1'b1; A = 9'd6; B = 9'd7; CE = 1'b0; end
                3:       begin IN_VALID = 1'b1; A = 9'd6; B = 9'd7; CE = 1'b1; end
                default: begin IN_VALID = 1'b0; A = 9'($urandom); B = 9'($urandom); CE = 1'b1; end
            endcase
            cycle();
            check_all("stall");
            if (last_ce && sw_ov[8]) got_q.push_back(sw_z[8]);
        end
        check("stall sample count", 32'(got_q.size()), 32'd3);
        if (got_q.size() == 3) begin
            check("stall z0", 32'(got_q[0]), 32'd6);
            check("stall z1", 32'(got_q[1]), 32'd20);
            check("stall z2", 32'(got_q[2]), 32'd42);
        end

        // Accumulator: load 12, add 30, invalid sample holds, add 1.
        flush();
        for (int i = 0; i < 6; i++) begin
            logic        ev;
            logic [19:0] ez;
            case (i)
                0:       begin IN_VALID = 1'b1; LOAD = 1'b1; A = 9'd3; B = 9'd4; end
                1:       begin IN_VALID = 1'b1; LOAD = 1'b0; A = 9'd5; B = 9'd6; end
                2:       begin IN_VALID = 1'b0; LOAD = 1'b1; A = 9'd9; B = 9'd9; end
                3:       begin IN_VALID = 1'b1; LOAD = 1'b0; A = 9'd1; B = 9'd1; end
                default: begin IN_VALID = 1'b0; LOAD = 1'b0; A = 9'd0; B = 9'd0; end
            endcase
            cycle();
            case (i)
                1:       begin ev = 1'b1; ez = 20'd12; end
                2:       begin ev = 1'b1; ez = 20'd42; end
                3:       begin ev = 1'b0; ez = 20'd42; end
                4:       begin ev = 1'b1; ez = 20'd43; end
                default: begin ev = 1'b0; ez = 20'd43; end
            endcase
            if (i >= 1) begin
                check($sformatf("acc step%0d valid", i), 32'(acc_ov), 32'(ev));
                check($sformatf("acc step%0d z", i), 32'(acc_z), 32'(ez));
            end
        end

        // Sync clear while stalled, then an asynchronous reset pulse between edges.
        flush();
        A = 9'd10; B = 9'd10; IN_VALID = 1'b1;
        cycle();
        CE = 1'b0; SRST = 1'b1; IN_VALID = 1'b0;
        cycle();
        check("srst valid", 32'(sw_ov[8]), 32'd0);
        check("srst z", 32'(sw_z[8]), 32'd0);
        check("srst acc z", 32'(acc_z), 32'd0);
        check_all("srst");
        SRST = 1'b0; CE = 1'b1; A = 9'd7; B = 9'd9; IN_VALID = 1'b1;
        cycle();
        cycle();
        check("pre-rst z", 32'(sw_z[8]), 32'd63);
        #2 RST = 1'b1;
        model_clear();
        #1;
        check("async rst valid", 32'(sw_ov[8]), 32'd0);
        check("async rst z", 32'(sw_z[8]), 32'd0);
        check("async rst acc valid", 32'(acc_ov), 32'd0);
        check_all("async_rst");
        #1 RST = 1'b0;
        cycle();
        check_all("post_rst");

        // Random traffic with stalls and occasional clears.
        for (int i = 0; i < 300; i++) begin
            A        = 9'($urandom);
            B        = 9'($urandom);
            IN_VALID = 1'($urandom);
            LOAD     = 1'($urandom);
            CE       = ($urandom_range(0, 4) != 0);
            SRST     = ($urandom_range(0, 29) == 0);
            cycle();
            check_all("rand");
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
